// File: rtl/gray_conv_sched.sv
// Round-robin shared binary<->Gray converter with a buffered, id-tagged
// valid/ready response port. One transaction in flight at a time.
module gray_conv_sched #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req0_mode,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_mode,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_mode,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CAPT, CONV, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             op_mode;
  logic             op_id;
  logic [WIDTH-1:0] op_data;
  logic [WIDTH-1:0] conv_data;
  logic             grant0;
  logic             grant1;

  // mode 0: binary->Gray, mode 1: Gray->binary (prefix XOR from the MSB down)
  function automatic logic [WIDTH-1:0] convert(input logic [WIDTH-1:0] v,
                                               input logic m);
    logic [WIDTH-1:0] r;
    r = v;
    if (!m) begin
      r = v ^ (v >> 1);
    end else begin
      for (int i = WIDTH - 2; i >= 0; i--) r[i] = r[i+1] ^ v[i];
    end
    return r;
  endfunction

  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  // ready is gated by rst_n so nothing is accepted while reset is held
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_mode    <= 1'b0;
      op_id      <= 1'b0;
      op_data    <= '0;
      conv_data  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_mode   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_id      <= grant1;
            op_mode    <= grant1 ? req1_mode : req0_mode;
            op_data    <= grant1 ? req1_data : req0_data;
            last_grant <= grant1;
            state      <= CAPT;
          end
        end
        CAPT: begin
          conv_data <= convert(op_data, op_mode);
          state     <= CONV;
        end
        CONV: begin
          rsp_data  <= conv_data;
          rsp_id    <= op_id;
          rsp_mode  <= op_mode;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
